// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU, beq/j resolution, and HI/LO with an
// iterative signed shift-add multiplier. Produces the registered XM_* bundle.
module execute_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] DX_PC,
    input  logic [DATA_W-1:0] JAddr,
    input  logic              Jump,
    input  logic              Branch,
    input  logic              DX_MemWrite,
    input  logic              DX_MemToReg,
    input  logic              DX_RegWrite,
    input  logic              lhWrite,
    input  logic              lhRead,
    input  logic              mflo,
    input  logic              ALUSrc,
    input  logic [2:0]        ALUCtr,
    input  logic [RD_W-1:0]   RD,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] Imm,
    output logic [DATA_W-1:0] XM_ALUout,
    output logic [DATA_W-1:0] XM_B,
    output logic [RD_W-1:0]   XM_RD,
    output logic              XM_MemWrite,
    output logic              XM_MemToReg,
    output logic              XM_RegWrite,
    output logic              XM_Redirect,
    output logic [DATA_W-1:0] XM_Target,
    output logic              mul_busy,
    output logic              ex_stall
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [2*DATA_W-1:0]     r_mcand;
    logic [2*DATA_W-1:0]     r_acc;
    logic [DATA_W-1:0]       r_mplier;
    logic                    r_sign;
    logic [DATA_W-1:0]       r_hi;
    logic [DATA_W-1:0]       r_lo;

    logic [DATA_W-1:0]       r_alu_p1;
    logic [DATA_W-1:0]       r_b_p1;
    logic [RD_W-1:0]         r_rd_p1;
    logic                    r_memwrite_p1;
    logic                    r_memtoreg_p1;
    logic                    r_regwrite_p1;
    logic                    r_redirect_p1;
    logic [DATA_W-1:0]       r_target_p1;

    logic signed [DATA_W-1:0] w_a_s;
    logic signed [DATA_W-1:0] w_op2_s;
    logic [DATA_W-1:0]        w_alu;
    logic [DATA_W-1:0]        w_result;
    logic [DATA_W-1:0]        w_btarget;
    logic [DATA_W-1:0]        w_abs_a;
    logic [DATA_W-1:0]        w_abs_b;
    logic                     w_bubble;
    logic                     w_ctl_kill;
    logic                     w_redirect;

    assign mul_busy = (r_state != S_IDLE);
    assign ex_stall = mul_busy & (lhRead | lhWrite);

    always_comb begin
        w_a_s   = A;
        w_op2_s = ALUSrc ? Imm : B;
        case (ALUCtr)
            3'b110:  w_alu = w_a_s - w_op2_s;
            3'b000:  w_alu = w_a_s & w_op2_s;
            3'b001:  w_alu = w_a_s | w_op2_s;
            3'b111:  w_alu = {{(DATA_W-1){1'b0}}, (w_a_s < w_op2_s)};
            default: w_alu = w_a_s + w_op2_s;
        endcase
        w_result  = lhRead ? (mflo ? r_lo : r_hi) : w_alu;
        w_btarget = DX_PC + {Imm[DATA_W-3:0], 2'b00};
        w_abs_a   = A[DATA_W-1] ? -A : A;
        w_abs_b   = B[DATA_W-1] ? -B : B;
        // A mult retires nothing into XM itself, and a stalled slot must not commit anything.
        w_bubble   = ex_stall | lhWrite;
        w_ctl_kill = w_bubble | Jump | Branch;
        w_redirect = !ex_stall & (Jump | (Branch & (A == B)));
    end

    // EX -> XM boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_p1      <= '0;
            r_b_p1        <= '0;
            r_rd_p1       <= '0;
            r_memwrite_p1 <= 1'b0;
            r_memtoreg_p1 <= 1'b0;
            r_regwrite_p1 <= 1'b0;
            r_redirect_p1 <= 1'b0;
            r_target_p1   <= '0;
        end else begin
            r_alu_p1      <= w_result;
            r_b_p1        <= B;
            r_rd_p1       <= RD;
            r_memwrite_p1 <= DX_MemWrite & !w_ctl_kill;
            r_memtoreg_p1 <= DX_MemToReg & !w_bubble;
            r_regwrite_p1 <= DX_RegWrite & !w_ctl_kill;
            r_redirect_p1 <= w_redirect;
            r_target_p1   <= Jump ? JAddr : w_btarget;
        end
    end

    // Multiplier FSM: magnitudes multiplied unsigned, sign applied once in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (lhWrite && !ex_stall) begin
                        r_mcand  <= {{DATA_W{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_acc    <= '0;
                        r_sign   <= A[DATA_W-1] ^ B[DATA_W-1];
                        r_cnt    <= '0;
                        r_state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W-1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    {r_hi, r_lo} <= r_sign ? -r_acc : r_acc;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign XM_ALUout   = r_alu_p1;
    assign XM_B        = r_b_p1;
    assign XM_RD       = r_rd_p1;
    assign XM_MemWrite = r_memwrite_p1;
    assign XM_MemToReg = r_memtoreg_p1;
    assign XM_RegWrite = r_regwrite_p1;
    assign XM_Redirect = r_redirect_p1;
    assign XM_Target   = r_target_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, beq/j redirect, mult/mfhi/mflo timing,
// HI/LO stall behaviour and asynchronous reset mid-multiply.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] DX_PC, JAddr, A, B, Imm;
    logic        Jump, Branch, DX_MemWrite, DX_MemToReg, DX_RegWrite;
    logic        lhWrite, lhRead, mflo, ALUSrc;
    logic [2:0]  ALUCtr;
    logic [4:0]  RD;
    logic [31:0] XM_ALUout, XM_B, XM_Target;
    logic [4:0]  XM_RD;
    logic        XM_MemWrite, XM_MemToReg, XM_RegWrite, XM_Redirect, mul_busy, ex_stall;

    int n_vec = 0;
    int n_err = 0;
    int cnt;

    execute_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .DX_PC(DX_PC), .JAddr(JAddr), .Jump(Jump), .Branch(Branch),
        .DX_MemWrite(DX_MemWrite), .DX_MemToReg(DX_MemToReg), .DX_RegWrite(DX_RegWrite),
        .lhWrite(lhWrite), .lhRead(lhRead), .mflo(mflo), .ALUSrc(ALUSrc), .ALUCtr(ALUCtr),
        .RD(RD), .A(A), .B(B), .Imm(Imm),
        .XM_ALUout(XM_ALUout), .XM_B(XM_B), .XM_RD(XM_RD), .XM_MemWrite(XM_MemWrite),
        .XM_MemToReg(XM_MemToReg), .XM_RegWrite(XM_RegWrite), .XM_Redirect(XM_Redirect),
        .XM_Target(XM_Target), .mul_busy(mul_busy), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        DX_PC = 32'h0; JAddr = 32'h0; A = 32'h0; B = 32'h0; Imm = 32'h0;
        Jump = 0; Branch = 0; DX_MemWrite = 0; DX_MemToReg = 0; DX_RegWrite = 0;
        lhWrite = 0; lhRead = 0; mflo = 0; ALUSrc = 0; ALUCtr = 3'b010; RD = 5'd0;
    endtask

    task automatic alu(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b,
                       input logic src, input logic [31:0] imm);
        nop();
        ALUCtr = ctr; A = a; B = b; ALUSrc = src; Imm = imm; DX_RegWrite = 1; RD = 5'd3;
        tick();
    endtask

    task automatic mult(input logic [31:0] a, input logic [31:0] b);
        nop();
        lhWrite = 1; DX_RegWrite = 1; A = a; B = b;
        tick();
        nop();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && mul_busy; i++) tick();
        chk("wait_idle", mul_busy, 1'b0);
    endtask

    task automatic read_hilo(input logic lo, input logic [31:0] exp, input string tag);
        nop();
        lhRead = 1; mflo = lo; DX_RegWrite = 1; RD = 5'd8;
        tick();
        chk(tag, XM_ALUout, exp);
        nop();
    endtask

    initial begin
        nop();
        rst = 1;
        #2;
        chk("rst_alu", XM_ALUout, 32'h0);
        chk("rst_regwrite", XM_RegWrite, 1'b0);
        chk("rst_busy", mul_busy, 1'b0);
        tick();
        rst = 0;

        alu(3'b010, 32'd5, 32'h0, 1'b1, 32'hFFFFFFF9);
        chk("add_imm", XM_ALUout, 32'hFFFFFFFE);
        chk("add_regwrite", XM_RegWrite, 1'b1);
        chk("add_rd", XM_RD, 32'd3);
        alu(3'b110, 32'd0, 32'd1, 1'b0, 32'd100);
        chk("sub", XM_ALUout, 32'hFFFFFFFF);
        alu(3'b111, 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0);
        chk("slt_neg", XM_ALUout, 32'd1);
        alu(3'b111, 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0);
        chk("slt_pos", XM_ALUout, 32'd0);
        alu(3'b000, 32'h0000F0F0, 32'h00000FF0, 1'b0, 32'd0);
        chk("and", XM_ALUout, 32'h000000F0);
        alu(3'b001, 32'h0000F0F0, 32'h00000FF0, 1'b0, 32'd0);
        chk("or", XM_ALUout, 32'h0000FFF0);
        alu(3'b011, 32'd2, 32'd3, 1'b0, 32'd0);
        chk("default_add", XM_ALUout, 32'd5);

        nop(); DX_MemWrite = 1; B = 32'hDEADBEEF; A = 32'h1000; Imm = 32'h4; ALUSrc = 1;
        tick();
        chk("sw_b", XM_B, 32'hDEADBEEF);
        chk("sw_memwrite", XM_MemWrite, 1'b1);
        chk("sw_addr", XM_ALUout, 32'h1004);

        nop(); Branch = 1; DX_PC = 32'h100; A = 32'd3; B = 32'd3; Imm = 32'hFFFFFFFE; DX_RegWrite = 1;
        tick();
        chk("beq_redirect", XM_Redirect, 1'b1);
        chk("beq_target", XM_Target, 32'h000000F8);
        chk("beq_regwrite", XM_RegWrite, 1'b0);
        nop();
        tick();
        chk("redirect_clear", XM_Redirect, 1'b0);
        nop(); Branch = 1; DX_PC = 32'h100; A = 32'd3; B = 32'd4; Imm = 32'd8;
        tick();
        chk("bne_redirect", XM_Redirect, 1'b0);
        nop(); Jump = 1; JAddr = 32'h00400020; DX_RegWrite = 1; DX_MemWrite = 1;
        tick();
        chk("j_redirect", XM_Redirect, 1'b1);
        chk("j_target", XM_Target, 32'h00400020);
        chk("j_regwrite", XM_RegWrite, 1'b0);
        chk("j_memwrite", XM_MemWrite, 1'b0);
        nop(); Jump = 1; Branch = 1; JAddr = 32'h00000400; DX_PC = 32'h200; A = 32'd1; B = 32'd1; Imm = 32'd4;
        tick();
        chk("j_wins", XM_Target, 32'h00000400);

        nop(); lhWrite = 1; DX_RegWrite = 1; A = 32'hFFFFFFFD; B = 32'd7;
        #1;
        chk("mult_nostall", ex_stall, 1'b0);
        tick();
        nop();
        chk("mult_bubble", XM_RegWrite, 1'b0);
        cnt = 0;
        for (int i = 0; i < 64 && mul_busy; i++) begin
            cnt++;
            tick();
        end
        chk("mult_busy_cycles", cnt, 32'd33);
        read_hilo(1'b1, 32'hFFFFFFEB, "mflo_m3x7");
        read_hilo(1'b0, 32'hFFFFFFFF, "mfhi_m3x7");

        mult(32'h80000000, 32'hFFFFFFFF);
        tick();
        lhRead = 1; mflo = 1; DX_RegWrite = 1; RD = 5'd9;
        #1;
        chk("mflo_stall", ex_stall, 1'b1);
        cnt = 0;
        for (int i = 0; i < 64 && ex_stall; i++) begin
            cnt++;
            tick();
            chk("stall_bubble", {30'd0, XM_RegWrite, XM_Redirect}, 32'd0);
        end
        chk("stall_cycles", cnt, 32'd32);
        tick();
        chk("mflo_min", XM_ALUout, 32'h80000000);
        chk("mflo_min_rw", XM_RegWrite, 1'b1);
        read_hilo(1'b0, 32'h00000000, "mfhi_min");

        mult(32'h00000000, 32'hFFFFFFFB);
        wait_idle();
        read_hilo(1'b1, 32'h0, "mflo_zero");
        read_hilo(1'b0, 32'h0, "mfhi_zero");

        mult(32'h7FFFFFFF, 32'h7FFFFFFF);
        nop(); ALUCtr = 3'b010; A = 32'd10; B = 32'd20; DX_RegWrite = 1; RD = 5'd4;
        #1;
        chk("indep_nostall", ex_stall, 1'b0);
        tick();
        chk("indep_add", XM_ALUout, 32'd30);
        chk("indep_rw", XM_RegWrite, 1'b1);
        chk("indep_busy", mul_busy, 1'b1);
        nop();
        wait_idle();
        read_hilo(1'b1, 32'h00000001, "mflo_max");
        read_hilo(1'b0, 32'h3FFFFFFF, "mfhi_max");

        nop(); Jump = 1; JAddr = 32'h12345678;
        tick();
        mult(32'd123, 32'd456);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_busy", mul_busy, 1'b1);
        rst = 1;
        #1;
        chk("rst_mid_busy", mul_busy, 1'b0);
        chk("rst_mid_target", XM_Target, 32'h0);
        tick();
        chk("rst_mid_redirect", XM_Redirect, 1'b0);
        rst = 0;
        read_hilo(1'b1, 32'h0, "rst_lo");
        read_hilo(1'b0, 32'h0, "rst_hi");
        chk("rst_idle", mul_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
